// File: rtl/i2c_slave_regfile.sv
// I2C target with a NUM_REGS x 8 register file, auto-incrementing pointer and host-side access port.
// SCL/SDA are synchronised and glitch-filtered on clk; host_rdata is combinational, I2C commits are strobed.
module i2c_slave_regfile #(
    parameter logic [6:0] SLAVE_ADDR = 7'h2A,
    parameter int         NUM_REGS   = 16,
    parameter int         FILTER_LEN = 3,
    localparam int        PTR_W      = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             sda_oe,
    input  logic             host_we,
    input  logic [PTR_W-1:0] host_addr,
    input  logic [7:0]       host_wdata,
    output logic [7:0]       host_rdata,
    output logic             i2c_wr_pulse,
    output logic [PTR_W-1:0] i2c_wr_addr,
    output logic [7:0]       i2c_wr_data,
    output logic             busy
);
    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]       filt_q, filt_d, filt_prev_q, filt_prev_d;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             ph_q, ph_d, rw_q, rw_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             sda_oe_q, sda_oe_d, wr_pulse_q, wr_pulse_d;
    logic [PTR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic [7:0]       regs_q [NUM_REGS];
    logic [7:0]       regs_d [NUM_REGS];

    logic scl_rise, scl_fall, start_det, stop_det, byte_done, ptr_ok, host_in_range;
    logic [7:0]       rx_byte;
    logic [PTR_W-1:0] next_ptr;

    // Filters preset to the idle-bus level so reset never fabricates a START.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 2'b11;
            sync2_q     <= 2'b11;
            filt_q      <= 2'b11;
            filt_prev_q <= 2'b11;
            cnt_q[0]    <= '0;
            cnt_q[1]    <= '0;
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd7;
            shift_q     <= '0;
            ph_q        <= 1'b0;
            rw_q        <= 1'b0;
            ptr_q       <= '0;
            sda_oe_q    <= 1'b0;
            wr_pulse_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            filt_q      <= filt_d;
            filt_prev_q <= filt_prev_d;
            cnt_q[0]    <= cnt_d[0];
            cnt_q[1]    <= cnt_d[1];
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ph_q        <= ph_d;
            rw_q        <= rw_d;
            ptr_q       <= ptr_d;
            sda_oe_q    <= sda_oe_d;
            wr_pulse_q  <= wr_pulse_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            regs_q      <= regs_d;
        end
    end

    always_comb begin
        sync1_d     = {sda_i, scl_i};
        sync2_d     = sync1_q;
        filt_prev_d = filt_q;
        filt_d      = filt_q;
        cnt_d[0]    = '0;
        cnt_d[1]    = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != filt_q[i]) begin
                if (cnt_q[i] == CNT_W'(FILTER_LEN - 1)) filt_d[i] = sync2_q[i];
                else                                     cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end

        // Index 0 is SCL, index 1 is SDA.
        scl_rise  = filt_q[0] & ~filt_prev_q[0];
        scl_fall  = ~filt_q[0] & filt_prev_q[0];
        start_det = filt_q[0] & filt_prev_q[0] & filt_prev_q[1] & ~filt_q[1];
        stop_det  = filt_q[0] & filt_prev_q[0] & ~filt_prev_q[1] & filt_q[1];
        rx_byte   = {shift_q[6:0], filt_q[1]};
        byte_done = scl_rise && (bit_cnt_q == 3'd0);
        ptr_ok    = ({1'b0, rx_byte} < 9'(NUM_REGS));
        next_ptr  = (ptr_q == PTR_W'(NUM_REGS - 1)) ? '0 : ptr_q + 1'b1;
        host_in_range = ({1'b0, host_addr} < (PTR_W + 1)'(NUM_REGS));

        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        ph_d       = ph_q;
        rw_d       = rw_q;
        ptr_d      = ptr_q;
        sda_oe_d   = sda_oe_q;
        wr_pulse_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        regs_d     = regs_q;
        if (host_we && host_in_range) regs_d[host_addr] = host_wdata;

        if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = 3'd7;
            sda_oe_d  = 1'b0;
            ph_d      = 1'b0;
        end else if (stop_det) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            ph_d     = 1'b0;
        end else begin
            if ((state_q == ADDR || state_q == PTR || state_q == WDATA) && scl_rise) begin
                shift_d   = rx_byte;
                bit_cnt_d = bit_cnt_q - 3'd1;
            end
            case (state_q)
                IDLE: ;
                ADDR: if (byte_done) begin
                    if (rx_byte[7:1] == SLAVE_ADDR) begin
                        state_d = ADDR_ACK;
                        rw_d    = rx_byte[0];
                    end else begin
                        state_d = IDLE;
                    end
                end
                PTR: if (byte_done) begin
                    if (ptr_ok) begin
                        ptr_d   = rx_byte[PTR_W-1:0];
                        state_d = PTR_ACK;
                    end else begin
                        state_d = IDLE;
                    end
                end
                WDATA: if (byte_done) begin
                    // Written after the host write above, so the I2C byte wins a same-index collision.
                    regs_d[ptr_q] = rx_byte;
                    wr_pulse_d    = 1'b1;
                    wr_addr_d     = ptr_q;
                    wr_data_d     = rx_byte;
                    ptr_d         = next_ptr;
                    state_d       = WDATA_ACK;
                end
                ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                    if (scl_rise) ph_d = 1'b1;
                    if (scl_fall) begin
                        if (!ph_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            ph_d      = 1'b0;
                            bit_cnt_d = 3'd7;
                            sda_oe_d  = 1'b0;
                            if (state_q == ADDR_ACK && rw_q) begin
                                shift_d  = regs_q[ptr_q];
                                sda_oe_d = ~regs_q[ptr_q][7];
                                state_d  = RDATA;
                            end else if (state_q == ADDR_ACK) begin
                                state_d = PTR;
                            end else begin
                                state_d = WDATA;
                            end
                        end
                    end
                end
                RDATA: begin
                    if (scl_fall) begin
                        shift_d  = {shift_q[6:0], 1'b0};
                        sda_oe_d = ~shift_q[6];
                    end
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q - 3'd1;
                        if (bit_cnt_q == 3'd0) state_d = RDATA_ACK;
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise) begin
                        if (filt_q[1]) begin
                            state_d  = IDLE;
                            sda_oe_d = 1'b0;
                        end else begin
                            ph_d  = 1'b1;
                            ptr_d = next_ptr;
                        end
                    end
                    if (scl_fall) begin
                        if (!ph_q) begin
                            sda_oe_d = 1'b0;
                        end else begin
                            ph_d      = 1'b0;
                            bit_cnt_d = 3'd7;
                            shift_d   = regs_q[ptr_q];
                            sda_oe_d  = ~regs_q[ptr_q][7];
                            state_d   = RDATA;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        sda_oe       = sda_oe_q;
        i2c_wr_pulse = wr_pulse_q;
        i2c_wr_addr  = wr_addr_q;
        i2c_wr_data  = wr_data_q;
        busy         = (state_q != IDLE) && (state_q != ADDR);
        host_rdata   = '0;
        if (host_in_range) host_rdata = regs_q[host_addr];
    end
endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Randomised I2C master driving i2c_slave_regfile, with a transaction-level register model and scoreboard.
module tb_i2c_slave_regfile;
    localparam int NR = 16;
    localparam int Q  = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_m, sda_m;
    logic       sda_line;
    logic       sda_oe, host_we, i2c_wr_pulse, busy;
    logic [3:0] host_addr, i2c_wr_addr;
    logic [7:0] host_wdata, host_rdata, i2c_wr_data;

    always #5 clk = ~clk;
    assign sda_line = sda_m & ~sda_oe;

    i2c_slave_regfile dut (
        .clk(clk), .rst(rst), .scl_i(scl_m), .sda_i(sda_line), .sda_oe(sda_oe),
        .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
        .i2c_wr_pulse(i2c_wr_pulse), .i2c_wr_addr(i2c_wr_addr), .i2c_wr_data(i2c_wr_data), .busy(busy)
    );

    int         checks = 0, errors = 0;
    logic [7:0] model [NR];
    int         mptr;
    logic [7:0] data_q[$];
    int         exp_wr_q[$];
    string      exp_tag_q[$];
    int         exp_val_q[$];
    int         obs_val_q[$];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    // Scoreboard: bus responses observed by the master against queued expectations.
    always @(posedge clk) begin
        while (obs_val_q.size() > 0) begin
            int o;
            o = obs_val_q.pop_front();
            if (exp_val_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_underflow: got 0x%0h, required no response", o);
            end else begin
                string t;
                int e;
                t = exp_tag_q.pop_front();
                e = exp_val_q.pop_front();
                check(t, o, e);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && i2c_wr_pulse) begin
            if (exp_wr_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_wr_pulse: got idx %0d data 0x%0h, required none", i2c_wr_addr, i2c_wr_data);
            end else begin
                int e;
                e = exp_wr_q.pop_front();
                check("wr_addr", int'(i2c_wr_addr), e >> 8);
                check("wr_data", int'(i2c_wr_data), e & 255);
            end
        end
    end

    task automatic w(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic put_bit(input logic b, input logic glitch);
        w(Q); sda_m = b; w(Q); scl_m = 1'b1;
        if (glitch) begin
            w(Q); sda_m = 1'b0; w(1); sda_m = b; w(Q - 1);
        end else begin
            w(2 * Q);
        end
        scl_m = 1'b0;
    endtask

    task automatic get_bit(output logic b);
        w(Q); sda_m = 1'b1; w(Q); scl_m = 1'b1; w(Q); b = sda_line; w(Q); scl_m = 1'b0;
    endtask

    task automatic start_c();
        w(Q); sda_m = 1'b1; w(Q); scl_m = 1'b1; w(Q); sda_m = 1'b0; w(Q); scl_m = 1'b0;
    endtask

    task automatic stop_c();
        w(Q); sda_m = 1'b0; w(Q); scl_m = 1'b1; w(Q); sda_m = 1'b1; w(4 * Q);
        check("busy_after_stop", int'(busy), 0);
        check("wr_pending", exp_wr_q.size(), 0);
        exp_wr_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] d, input string tag, input int exp_ack, input int gbit);
        logic a;
        exp_tag_q.push_back(tag);
        exp_val_q.push_back(exp_ack);
        for (int i = 7; i >= 0; i--) put_bit(d[i], i == gbit);
        get_bit(a);
        obs_val_q.push_back(int'(a));
    endtask

    task automatic recv_byte(input logic [7:0] exp, input logic ack);
        logic [7:0] d;
        logic b;
        exp_tag_q.push_back("rd_data");
        exp_val_q.push_back(int'(exp));
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            d[i] = b;
        end
        obs_val_q.push_back(int'(d));
        put_bit(ack, 1'b0);
    endtask

    task automatic host_write(input int idx, input logic [7:0] d);
        host_addr = 4'(idx); host_wdata = d; host_we = 1'b1; w(1); host_we = 1'b0;
        model[idx] = d;
    endtask

    // Write data_q starting at pointer p; pointers >= NR are refused and leave the model pointer alone.
    task automatic tx_write(input int p);
        start_c();
        send_byte(8'h54, "addr_ack", 0, -1);
        check("busy_after_match", int'(busy), 1);
        if (p >= NR) begin
            send_byte(8'(p), "ptr_nack", 1, -1);
            check("busy_after_ptr_nack", int'(busy), 0);
        end else begin
            send_byte(8'(p), "ptr_ack", 0, -1);
            mptr = p;
            foreach (data_q[k]) begin
                exp_wr_q.push_back((mptr << 8) | int'(data_q[k]));
                model[mptr] = data_q[k];
                send_byte(data_q[k], "data_ack", 0, -1);
                mptr = (mptr + 1) % NR;
            end
        end
        stop_c();
    endtask

    task automatic tx_read(input int p, input int n, input logic set_ptr);
        if (set_ptr) begin
            start_c();
            send_byte(8'h54, "addr_ack", 0, -1);
            send_byte(8'(p), "ptr_ack", 0, -1);
            mptr = p;
        end
        start_c();
        send_byte(8'h55, "rd_addr_ack", 0, -1);
        for (int k = 0; k < n; k++) begin
            recv_byte(model[mptr], (k == n - 1));
            if (k < n - 1) mptr = (mptr + 1) % NR;
        end
        check("busy_after_nack", int'(busy), 0);
        stop_c();
    endtask

    task automatic tx_badaddr(input int a);
        start_c();
        send_byte(8'(a << 1), "addr_nack", 1, -1);
        check("busy_after_mismatch", int'(busy), 0);
        send_byte(8'($urandom_range(0, 255)), "ignored_byte", 1, -1);
        stop_c();
    endtask

    task automatic check_all_regs();
        for (int i = 0; i < NR; i++) begin
            host_addr = 4'(i); w(1);
            check("host_rdata", int'(host_rdata), int'(model[i]));
        end
    endtask

    initial begin
        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
        host_we = 1'b0; host_addr = '0; host_wdata = '0;
        for (int i = 0; i < NR; i++) model[i] = '0;
        mptr = 0;
        w(3);
        check("rst_sda_oe", int'(sda_oe), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_wr_pulse", int'(i2c_wr_pulse), 0);
        check("rst_wr_addr", int'(i2c_wr_addr), 0);
        check("rst_wr_data", int'(i2c_wr_data), 0);
        rst = 1'b0; w(4);
        check_all_regs();

        data_q = '{8'hA5, 8'h5A};
        tx_write(3);
        tx_read(3, 2, 1'b1);
        tx_badaddr(7'h2B);
        data_q = '{8'h11, 8'h22};
        tx_write(15);
        tx_write(16);
        tx_read(0, 1, 1'b0);

        // Glitched data bit, then host write colliding with the I2C commit to index 4.
        start_c();
        send_byte(8'h54, "addr_ack", 0, -1);
        send_byte(8'h03, "ptr_ack", 0, -1);
        exp_wr_q.push_back((3 << 8) | 8'hFF);
        model[3] = 8'hFF;
        send_byte(8'hFF, "glitch_data_ack", 0, 6);
        exp_wr_q.push_back((4 << 8) | 8'h96);
        model[4] = 8'h96;
        fork
            begin
                host_addr = 4'd4; host_wdata = 8'hEE; host_we = 1'b1;
                for (int k = 0; k < 400 && !i2c_wr_pulse; k++) @(negedge clk);
                host_we = 1'b0;
            end
            send_byte(8'h96, "collide_data_ack", 0, -1);
        join
        mptr = 5;
        stop_c();
        check_all_regs();

        // Reset while the target drives a 0 data bit.
        host_write(7, 8'h3C);
        start_c();
        send_byte(8'h54, "addr_ack", 0, -1);
        send_byte(8'h07, "ptr_ack", 0, -1);
        start_c();
        send_byte(8'h55, "rd_addr_ack", 0, -1);
        w(Q); sda_m = 1'b1; w(Q); scl_m = 1'b1; w(Q);
        check("rd_drive_low", int'(sda_oe), 1);
        rst = 1'b1;
        #1;
        check("rst_release_sda", int'(sda_oe), 0);
        check("rst_busy_mid", int'(busy), 0);
        w(1); rst = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = '0;
        mptr = 0;
        w(Q); scl_m = 1'b0; w(Q); scl_m = 1'b1; w(4 * Q);
        check("busy_after_reset", int'(busy), 0);
        data_q = '{8'h77};
        tx_write(2);
        check_all_regs();

        for (int it = 0; it < 20; it++) begin
            int kind, p, n;
            kind = int'($urandom_range(0, 3));
            p    = int'($urandom_range(0, NR - 1));
            n    = int'($urandom_range(1, 3));
            case (kind)
                0: begin
                    data_q.delete();
                    for (int k = 0; k < n; k++) data_q.push_back(8'($urandom_range(0, 255)));
                    tx_write(p);
                end
                1: tx_read(p, n, 1'b1);
                2: tx_read(0, n, 1'b0);
                default: begin
                    if ($urandom_range(0, 1) == 0) begin
                        int a;
                        a = int'($urandom_range(0, 127));
                        if (a == 7'h2A) a = 7'h2B;
                        tx_badaddr(a);
                    end else begin
                        tx_write(int'($urandom_range(NR, 255)));
                    end
                end
            endcase
        end

        check_all_regs();
        w(4);
        check("sb_leftover", exp_val_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
